// File: rtl/mppt_sweep_pkg.sv
// Shared types and constants for the open-loop duty sweep generator.
package mppt_sweep_pkg;

  // Sweep FSM: IDLE parks the carrier, RUN_UP/RUN_DOWN walk the step counter.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_e;

  // Sweep shape selected by the mode input.
  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/duty_sweep_pwm_kn_map.sv
// Step index to duty word mapping: (cnt + KN_OFFSET) << KN_SHIFT, saturated
// to the largest value the PWM carrier can represent.
module kn_map #(
  parameter int CNT_W     = 6,
  parameter int KN_W      = 9,
  parameter int KN_OFFSET = 19,
  parameter int KN_SHIFT  = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  output logic [KN_W-1:0]  kn_o
);

  // One spare bit over KN_W+CNT_W keeps the offset sum from wrapping.
  localparam int SUM_W = KN_W + CNT_W + 1;

  logic [SUM_W-1:0] sum;

  assign sum = (SUM_W'(cnt_i) + SUM_W'(KN_OFFSET)) << KN_SHIFT;

  // Any bit above the carrier width means the duty would overflow: clamp.
  always_comb begin
    if (|sum[SUM_W-1:KN_W]) begin
      kn_o = '1;
    end else begin
      kn_o = sum[KN_W-1:0];
    end
  end

endmodule

// File: rtl/duty_sweep_pwm.sv
// Open-loop duty sweep generator: a step counter walks the operating range
// (sawtooth or triangle), each step is mapped to a duty word, and a PWM
// carrier applies that duty with updates only at period boundaries.
module duty_sweep_pwm
  import mppt_sweep_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int KN_W      = 9,
  parameter int KN_OFFSET = 19,
  parameter int KN_SHIFT  = 2,
  parameter int DWELL_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   cnt_max,
  output logic [CNT_W-1:0]   cnt,
  output logic [KN_W-1:0]    kn,
  output logic               dir,
  output logic               pwm,
  output logic               period_start,
  output logic               step
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [KN_W-1:0]    kn_q, kn_d;
  logic [KN_W-1:0]    pcnt_q, pcnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               step_q, step_d;

  logic               run;
  logic               period_end;
  logic [CNT_W-1:0]   map_in;
  logic [KN_W-1:0]    map_out;

  assign run        = (state_q != IDLE);
  assign period_end = run && (pcnt_q == '1);

  // Map the upcoming step index; under reset this yields the reset duty map(0).
  assign map_in = rst ? '0 : cnt_d;

  kn_map #(
    .CNT_W    (CNT_W),
    .KN_W     (KN_W),
    .KN_OFFSET(KN_OFFSET),
    .KN_SHIFT (KN_SHIFT)
  ) u_kn_map (
    .cnt_i(map_in),
    .kn_o (map_out)
  );

  // Next-state logic: FSM, carrier, dwell counter and step counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    pcnt_d      = pcnt_q;
    dwell_cnt_d = dwell_cnt_q;
    step_d      = 1'b0;

    case (state_q)
      IDLE: begin
        pcnt_d      = '0;
        dwell_cnt_d = '0;
        if (en) begin
          // Resume in whichever direction the sweep was heading.
          state_d = dir_q ? RUN_DOWN : RUN_UP;
        end
      end
      default: begin
        if (!en) begin
          // Park: carrier and dwell restart, sweep position is kept.
          state_d     = IDLE;
          pcnt_d      = '0;
          dwell_cnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
          if (period_end) begin
            if (dwell_cnt_q == dwell) begin
              dwell_cnt_d = '0;
              step_d      = 1'b1;
              if (mode == MODE_SAW) begin
                state_d = RUN_UP;
                cnt_d   = (cnt_q >= cnt_max) ? '0 : cnt_q + 1'b1;
              end else if (state_q == RUN_UP) begin
                if (cnt_max == '0) begin
                  cnt_d = '0;
                end else if (cnt_q >= cnt_max) begin
                  // Turn around without repeating the endpoint.
                  state_d = RUN_DOWN;
                  cnt_d   = cnt_max - 1'b1;
                end else begin
                  cnt_d = cnt_q + 1'b1;
                end
              end else begin
                if (cnt_q == '0) begin
                  state_d = RUN_UP;
                  cnt_d   = (cnt_max == '0) ? '0 : CNT_W'(1);
                end else begin
                  cnt_d = cnt_q - 1'b1;
                end
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
          end
        end
      end
    endcase

    // Direction follows the run state and is frozen while idle.
    if (state_d != IDLE) begin
      dir_d = (state_d == RUN_DOWN);
    end
  end

  // Shadow duty register only reloads at the period boundary.
  always_comb begin
    kn_d = kn_q;
    if (period_end) begin
      kn_d = map_out;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      kn_q        <= map_out;
      pcnt_q      <= '0;
      dwell_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      kn_q        <= kn_d;
      pcnt_q      <= pcnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_q      <= step_d;
    end
  end

  // Outputs decode registers only, so the gate signal cannot glitch.
  assign pwm          = run && (pcnt_q < kn_q);
  assign period_start = run && (pcnt_q == '0);
  assign step         = step_q;
  assign cnt          = cnt_q;
  assign kn           = kn_q;
  assign dir          = dir_q;

endmodule

// File: tb/tb_duty_sweep_pwm.sv
// Directed bench for duty_sweep_pwm: default build plus a saturating build.
module tb_duty_sweep_pwm;

  localparam int CNT_W   = 6;
  localparam int KN_W    = 9;
  localparam int DWELL_W = 8;
  localparam int PERIOD  = 512;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               mode = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [CNT_W-1:0]   cnt_max = '0;

  logic [CNT_W-1:0] a_cnt, b_cnt;
  logic [KN_W-1:0]  a_kn, b_kn;
  logic a_dir, a_pwm, a_ps, a_step;
  logic b_dir, b_pwm, b_ps, b_step;

  duty_sweep_pwm #(.CNT_W(CNT_W), .KN_W(KN_W), .KN_OFFSET(19), .KN_SHIFT(2), .DWELL_W(DWELL_W)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell), .cnt_max(cnt_max),
    .cnt(a_cnt), .kn(a_kn), .dir(a_dir), .pwm(a_pwm), .period_start(a_ps), .step(a_step)
  );

  duty_sweep_pwm #(.CNT_W(CNT_W), .KN_W(KN_W), .KN_OFFSET(120), .KN_SHIFT(2), .DWELL_W(DWELL_W)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell), .cnt_max(cnt_max),
    .cnt(b_cnt), .kn(b_kn), .dir(b_dir), .pwm(b_pwm), .period_start(b_ps), .step(b_step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic mode;
    int   dwell;
    int   cnt_max;
    int   nper;
    int   e_cnt;
    int   e_kn;
    int   e_dir;
    int   e_step;
  } vec_t;

  vec_t vecs[8];
  int   tri_seq[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Advance to the next period_start of dut_a, bounded.
  task automatic wait_ps(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      tick();
      if (a_ps) found = 1'b1;
    end
    if (!found) check({tag, "_ps_timeout"}, 0, 1);
  endtask

  // Count pwm-high cycles over one period starting at the current cycle.
  task automatic count_high(output int hi_a, output int hi_b);
    hi_a = int'(a_pwm);
    hi_b = int'(b_pwm);
    repeat (PERIOD - 1) begin
      tick();
      hi_a += int'(a_pwm);
      hi_b += int'(b_pwm);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi_a, hi_b, ev, cyc;

    //                 mode  dwell max nper cnt  kn  dir step
    vecs[0] = '{1'b0, 0, 63, 1, 1,  80, 0, 1};
    vecs[1] = '{1'b0, 0,  3, 4, 0,  76, 0, 1};
    vecs[2] = '{1'b0, 2, 10, 7, 2,  84, 0, 0};
    vecs[3] = '{1'b1, 0,  2, 3, 1,  80, 1, 1};
    vecs[4] = '{1'b1, 0,  2, 5, 1,  80, 0, 1};
    vecs[5] = '{1'b1, 0,  0, 2, 0,  76, 0, 1};
    vecs[6] = '{1'b0, 0,  0, 2, 0,  76, 0, 1};
    vecs[7] = '{1'b1, 0,  1, 2, 0,  76, 1, 1};
    tri_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    // Reset state and idle behaviour.
    do_reset();
    tick();
    check("rst_cnt", int'(a_cnt), 0);
    check("rst_kn", int'(a_kn), 76);
    check("rst_kn_b", int'(b_kn), 480);
    check("rst_dir", int'(a_dir), 0);
    check("rst_pwm", int'(a_pwm), 0);
    check("rst_ps", int'(a_ps), 0);
    check("rst_step", int'(a_step), 0);
    ev = 0;
    repeat (1000) begin
      tick();
      ev += int'(a_ps) + int'(a_step) + int'(a_pwm);
    end
    check("idle_events", ev, 0);
    check("idle_kn", int'(a_kn), 76);

    // Table: run N period boundaries from reset, then check state and duty.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      mode    = vecs[v].mode;
      dwell   = DWELL_W'(vecs[v].dwell);
      cnt_max = CNT_W'(vecs[v].cnt_max);
      en      = 1'b1;
      wait_ps($sformatf("v%0d_first", v));
      for (int p = 0; p < vecs[v].nper; p++) wait_ps($sformatf("v%0d", v));
      check($sformatf("v%0d_cnt", v), int'(a_cnt), vecs[v].e_cnt);
      check($sformatf("v%0d_kn", v), int'(a_kn), vecs[v].e_kn);
      check($sformatf("v%0d_dir", v), int'(a_dir), vecs[v].e_dir);
      check($sformatf("v%0d_step", v), int'(a_step), vecs[v].e_step);
      count_high(hi_a, hi_b);
      check($sformatf("v%0d_high", v), hi_a, vecs[v].e_kn);
    end

    // Full sawtooth sweep with wrap; saturating build rides along.
    do_reset();
    mode = 1'b0; dwell = '0; cnt_max = 6'd63; en = 1'b1;
    wait_ps("saw_first");
    check("saw_first_cnt", int'(a_cnt), 0);
    check("saw_first_step", int'(a_step), 0);
    count_high(hi_a, hi_b);
    check("saw_first_high", hi_a, 76);
    wait_ps("saw_p1");
    check("saw_p1_step", int'(a_step), 1);
    check("saw_p1_kn", int'(a_kn), 80);
    count_high(hi_a, hi_b);
    check("saw_p1_high", hi_a, 80);
    for (int p = 0; p < 62; p++) wait_ps("saw_run");
    check("saw_top_cnt", int'(a_cnt), 63);
    check("saw_top_kn", int'(a_kn), 328);
    check("sat_cnt", int'(b_cnt), 63);
    check("sat_kn", int'(b_kn), 511);
    count_high(hi_a, hi_b);
    check("saw_top_high", hi_a, 328);
    check("sat_low_cycles", PERIOD - hi_b, 1);
    wait_ps("saw_wrap");
    check("saw_wrap_cnt", int'(a_cnt), 0);
    check("saw_wrap_kn", int'(a_kn), 76);
    check("saw_wrap_step", int'(a_step), 1);
    check("sat_wrap_kn", int'(b_kn), 480);

    // Triangle with dwell 1: each value held two periods, single endpoint dwell.
    do_reset();
    mode = 1'b1; dwell = 8'd1; cnt_max = 6'd3; en = 1'b1;
    wait_ps("tri_first");
    check("tri_cnt0", int'(a_cnt), 0);
    for (int i = 1; i < 8; i++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!a_step && cyc < 1100);
      check($sformatf("tri%0d_gap", i), cyc, 1024);
      check($sformatf("tri%0d_cnt", i), int'(a_cnt), tri_seq[i]);
      if (i != 6) check($sformatf("tri%0d_dir", i), int'(a_dir), (i == 4 || i == 5) ? 1 : 0);
    end

    // Enable dropped mid-period, then resumed.
    do_reset();
    mode = 1'b0; dwell = '0; cnt_max = 6'd63; en = 1'b1;
    wait_ps("en_first");
    for (int p = 0; p < 5; p++) wait_ps("en_run");
    check("en_cnt", int'(a_cnt), 5);
    check("en_kn", int'(a_kn), 96);
    repeat (40) tick();
    check("en_pwm_before", int'(a_pwm), 1);
    en = 1'b0;
    tick();
    check("en_off_pwm", int'(a_pwm), 0);
    check("en_off_cnt", int'(a_cnt), 5);
    check("en_off_ps", int'(a_ps), 0);
    repeat (20) tick();
    check("en_idle_pwm", int'(a_pwm), 0);
    en = 1'b1;
    tick();
    check("en_resume_ps", int'(a_ps), 1);
    check("en_resume_kn", int'(a_kn), 96);
    check("en_resume_step", int'(a_step), 0);
    count_high(hi_a, hi_b);
    check("en_resume_high", hi_a, 96);
    check("en_resume_cnt", int'(a_cnt), 5);

    // Reset mid-period while sweeping down, with enable still high.
    do_reset();
    mode = 1'b1; dwell = '0; cnt_max = 6'd8; en = 1'b1;
    wait_ps("rd_first");
    for (int p = 0; p < 9; p++) wait_ps("rd_run");
    check("rd_cnt", int'(a_cnt), 7);
    check("rd_dir", int'(a_dir), 1);
    check("rd_kn", int'(a_kn), 104);
    repeat (200) tick();
    rst = 1'b1;
    tick();
    check("rd_rst_cnt", int'(a_cnt), 0);
    check("rd_rst_dir", int'(a_dir), 0);
    check("rd_rst_kn", int'(a_kn), 76);
    check("rd_rst_pwm", int'(a_pwm), 0);
    check("rd_rst_ps", int'(a_ps), 0);
    check("rd_rst_step", int'(a_step), 0);
    tick();
    check("rd_rst_hold_ps", int'(a_ps), 0);
    rst = 1'b0;
    tick();
    check("rd_restart_ps", int'(a_ps), 1);
    check("rd_restart_dir", int'(a_dir), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/duty_sweep_pwm.md
# duty_sweep_pwm

Parametrised open-loop duty sweep generator for MPPT characterisation. A step counter walks through the operating range in sawtooth or triangle mode and maps each step to a duty word `kn = (cnt + KN_OFFSET) << KN_SHIFT`. It drives a glitch-free PWM carrier whose duty is updated only at period boundaries. It sits between the open-loop control sequencer and the converter gate-drive output, and generalises the fixed 6-bit-to-9-bit step mapping used in the first open-loop build.

## Interface
- `CNT_W`, default 6: step counter width.
- `KN_W`, default 9: duty word and PWM carrier width; the PWM period is 2^KN_W cycles.
- `KN_OFFSET`, default 19: offset added to `cnt` before scaling.
- `KN_SHIFT`, default 2: left shift applied after the offset.
- `DWELL_W`, default 8: width of the dwell input.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: run enable.
- `mode`  in  1: 0 = sawtooth, 1 = triangle.
- `dwell`  in  DWELL_W: number of PWM periods per step, minus 1.
- `cnt_max`  in  CNT_W: upper end of the sweep.
- `cnt`  out  CNT_W: current step index.
- `kn`  out  KN_W: duty word currently applied (the shadow register).
- `dir`  out  1: 0 = counting up, 1 = counting down.
- `pwm`  out  1: gate output.
- `period_start`  out  1: one-cycle pulse on the first cycle of each PWM period.
- `step`  out  1: one-cycle pulse on the cycle in which `cnt` takes a new value.

## Operation
- FSM states are IDLE, RUN_UP and RUN_DOWN. `dir` is 1 only in RUN_DOWN.
- Reset values:
  - state = IDLE; `cnt` = 0; `dir` = 0; `pwm` = 0; `period_start` = 0; `step` = 0.
  - Carrier `pcnt` = 0; dwell counter = 0.
  - `kn` = map(0), which is 76 at the defaults.
- Mapping (sub-module `kn_map`):
  - Sum in KN_W+CNT_W+1 bits: `(cnt + KN_OFFSET) << KN_SHIFT`.
  - Saturate to 2^KN_W−1.
- State transitions:
  - IDLE → RUN_UP when `en` = 1.
  - Any RUN state → IDLE in the cycle after `en` = 0.
  - On entering IDLE: `pcnt` and the dwell counter clear; `cnt`, `dir` and `kn` are held.
  - Re-enable resumes from the held `cnt` in RUN_UP or RUN_DOWN according to the held `dir`.
- In RUN, `pcnt` increments every cycle and wraps from 2^KN_W−1 to 0.
- Period end (`pcnt` = 2^KN_W−1):
  - If the dwell counter equals `dwell`: the dwell counter clears and a step occurs.
  - Otherwise the dwell counter increments.
- Step, sawtooth:
  - `cnt` increments.
  - When `cnt` ≥ `cnt_max`, `cnt` goes to 0 instead.
- Step, triangle, RUN_UP:
  - When `cnt` ≥ `cnt_max`: go to RUN_DOWN and load `cnt` = `cnt_max`−1.
  - Otherwise `cnt` increments.
- Step, triangle, RUN_DOWN:
  - When `cnt` = 0: go to RUN_UP and load `cnt` = 1.
  - Otherwise `cnt` decrements.
- Triangle endpoints get a single dwell, never a double dwell.
- `cnt_max` = 0: `cnt` stays 0 and `step` still pulses.
- `cnt_max`, `dwell` and `mode` are sampled only at the step or period-end edge. Changing them mid-period takes effect at the next boundary.
- Changing `mode` from sawtooth to triangle while `dir` = 0 continues upward.

## Timing
- `kn` loads map(next `cnt`) on the period-end edge. The first cycle of every period therefore already uses the new duty.
- `pwm` = RUN && (`pcnt` < `kn`), decoded combinationally from registers, so it is glitch-free.
- `kn` = 0 gives constant low. Maximum duty is (2^KN_W−1)/2^KN_W; the output is never constant high.
- `period_start` = RUN && `pcnt` == 0. The first pulse occurs on the first RUN cycle.
- `step` is high on the first cycle in which the new `cnt` is visible, which coincides with `period_start`.
- `en` falling: `pwm` = 0 from the next cycle.
- `rst` has priority over `en` in the same cycle. Reset mid-period returns every output to its reset value on the next edge.
- Step latency: `cnt` advances every (`dwell`+1)·2^KN_W cycles.

## Structure
- Package `mppt_sweep_pkg` holds:
  - the FSM state enum (IDLE, RUN_UP, RUN_DOWN);
  - the mode constants MODE_SAW = 0 and MODE_TRI = 1.
- Sub-module `kn_map` (combinational; parameters CNT_W, KN_W, KN_OFFSET, KN_SHIFT) is instantiated once, on next-`cnt`.
- All other logic lives in the top: FSM, dwell counter, carrier, shadow register.

## Test plan
- Reset, then `en` = 0 → `kn` = 76, `pwm` = 0, `cnt` = 0; `period_start` and `step` stay 0 over 1000 cycles.
- `en` = 1, `mode` = 0, `dwell` = 0, `cnt_max` = 63 →
  - first period: `pwm` high exactly 76 cycles;
  - after 512 cycles: `step` pulses, `kn` = 80, `pwm` high 80 cycles;
  - `cnt` 63 → 0 with `kn` 328 → 76.
- `mode` = 1, `cnt_max` = 3, `dwell` = 1 → `cnt` sequence 0,1,2,3,2,1,0,1, each value held 1024 cycles; `dir` is 1 during 2,1.
- `KN_OFFSET` = 120 build, `cnt` = 63 → `kn` = 511; `pwm` low exactly 1 cycle per period.
- `en` dropped at `pcnt` = 40 with `cnt` = 5 → `pwm` = 0 next cycle. On re-enable, `pcnt` restarts at 0, `period_start` pulses and `kn` = 96.
- `rst` asserted at `pcnt` = 200 during RUN_DOWN, `cnt` = 7 → next cycle: IDLE, `cnt` = 0, `dir` = 0, `kn` = 76, `pwm` = 0.
